// File: rtl/ldbuf_pkg.sv
// Shared types and default widths for the load buffer tracker.
package ldbuf_pkg;

  localparam int XLEN_DEF       = 64;
  localparam int NR_ENTRIES_DEF = 2;
  localparam int ID_W_DEF       = 1;
  localparam int TRANS_ID_W_DEF = 3;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } ld_size_e;

  // trans_id is kept outside the struct so its width can follow the top parameter.
  typedef struct packed {
    logic       valid;
    logic       killed;
    logic [2:0] offset;
    ld_size_e   size;
    logic       is_signed;
  } ld_entry_t;

endpackage

// File: rtl/ld_data_align.sv
// Extracts the addressed bytes from a 64-bit dcache word and sign/zero-extends them.
module ld_data_align
  import ldbuf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw_data,
  input  logic [2:0]      offset,
  input  ld_size_e        size,
  input  logic            is_signed,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = raw_data >> {offset, 3'b000};
    result  = shifted;
    case (size)
      BYTE:    result = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
      WORD:    result = {{(XLEN-32){is_signed & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_buffer_tracker.sv
// Tracks outstanding dcache loads and produces aligned writebacks to the scoreboard.
// Define LDBUF_WB_REG_EN to register the writeback outputs (1-cycle latency).
module load_buffer_tracker
  import ldbuf_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NR_ENTRIES = NR_ENTRIES_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int TRANS_ID_W = TRANS_ID_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
  input  logic [2:0]            alloc_offset_i,
  input  logic [1:0]            alloc_size_i,
  input  logic                  alloc_signed_i,
  output logic [ID_W-1:0]       alloc_id_o,
  input  logic                  rsp_valid_i,
  input  logic [ID_W-1:0]       rsp_id_i,
  input  logic [XLEN-1:0]       rsp_data_i,
  output logic                  wb_valid_o,
  output logic [TRANS_ID_W-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [ID_W:0]         count_o,
  output logic                  protocol_err_o
);

  ld_entry_t             ent_q   [NR_ENTRIES];
  logic [TRANS_ID_W-1:0] tid_q   [NR_ENTRIES];
  logic [ID_W:0]         count_q;
  logic                  err_q;

  logic            free_found;
  logic [ID_W-1:0] free_id;
  logic            alloc_fire;
  logic            rsp_hit;
  logic            rsp_wb;
  logic [XLEN-1:0] aligned_data;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_found = 1'b1;
        free_id    = ID_W'(i);
      end
    end
  end

  assign alloc_ready_o = rst_ni & ~flush_i & free_found;
  assign alloc_id_o    = free_id;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  // Allocation only targets invalid entries and a hit needs a valid one, so they never collide.
  assign rsp_hit = rsp_valid_i & ent_q[rsp_id_i].valid;
  assign rsp_wb  = rsp_hit & ~ent_q[rsp_id_i].killed & ~flush_i;

  ld_data_align #(.XLEN(XLEN)) u_align (
    .raw_data  (rsp_data_i),
    .offset    (ent_q[rsp_id_i].offset),
    .size      (ent_q[rsp_id_i].size),
    .is_signed (ent_q[rsp_id_i].is_signed),
    .result    (aligned_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        ent_q[i] <= '0;
        tid_q[i] <= '0;
      end
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (flush_i && ent_q[i].valid) ent_q[i].killed <= 1'b1;
        if (rsp_hit && rsp_id_i == ID_W'(i)) begin
          ent_q[i].valid  <= 1'b0;
          ent_q[i].killed <= 1'b0;
        end
        if (alloc_fire && free_id == ID_W'(i)) begin
          ent_q[i].valid     <= 1'b1;
          ent_q[i].killed    <= 1'b0;
          ent_q[i].offset    <= alloc_offset_i;
          ent_q[i].size      <= ld_size_e'(alloc_size_i);
          ent_q[i].is_signed <= alloc_signed_i;
          tid_q[i]           <= alloc_trans_id_i;
        end
      end
      count_q <= count_q + {{ID_W{1'b0}}, alloc_fire} - {{ID_W{1'b0}}, rsp_hit};
      if (rsp_valid_i && !ent_q[rsp_id_i].valid) err_q <= 1'b1;
    end
  end

  assign count_o        = count_q;
  assign protocol_err_o = err_q;

`ifdef LDBUF_WB_REG_EN
  logic                  wb_valid_q;
  logic [TRANS_ID_W-1:0] wb_tid_q;
  logic [XLEN-1:0]       wb_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wb_valid_q <= 1'b0;
      wb_tid_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= rsp_wb;
      wb_tid_q   <= tid_q[rsp_id_i];
      wb_data_q  <= aligned_data;
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_trans_id_o = wb_tid_q;
  assign wb_data_o     = wb_data_q;
`else
  assign wb_valid_o    = rsp_wb;
  assign wb_trans_id_o = tid_q[rsp_id_i];
  assign wb_data_o     = aligned_data;
`endif

endmodule

// File: tb/tb_load_buffer_tracker.sv
// Self-checking bench for load_buffer_tracker: vector table, corner sequences and a writeback scoreboard.
module tb_load_buffer_tracker;

`ifdef LDBUF_WB_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_tid;
  logic [2:0]  alloc_off;
  logic [1:0]  alloc_size;
  logic        alloc_sgn;
  logic        alloc_id;
  logic        rsp_valid;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic        wb_valid;
  logic [2:0]  wb_tid;
  logic [63:0] wb_data;
  logic [1:0]  count;
  logic        perr;

  load_buffer_tracker dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .alloc_valid_i    (alloc_valid),
    .alloc_ready_o    (alloc_ready),
    .alloc_trans_id_i (alloc_tid),
    .alloc_offset_i   (alloc_off),
    .alloc_size_i     (alloc_size),
    .alloc_signed_i   (alloc_sgn),
    .alloc_id_o       (alloc_id),
    .rsp_valid_i      (rsp_valid),
    .rsp_id_i         (rsp_id),
    .rsp_data_i       (rsp_data),
    .wb_valid_o       (wb_valid),
    .wb_trans_id_o    (wb_tid),
    .wb_data_o        (wb_data),
    .count_o          (count),
    .protocol_err_o   (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  tid;
    logic [63:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [2:0]  tid;
    logic [2:0]  off;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference alignment: slide the field to the top of the word, then shift back down.
  function automatic logic [63:0] model(input logic [63:0] d, input int off, input int sz, input bit sgn);
    int w;
    logic [63:0] t;
    logic signed [63:0] ts;
    w  = 8 << sz;
    t  = d << (64 - off * 8 - w);
    ts = t;
    if (sgn) return ts >>> (64 - w);
    return t >> (64 - w);
  endfunction

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("wb_trans_id", 64'(wb_tid), 64'(e.tid));
        check("wb_data", wb_data, e.data);
        check("wb_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic do_alloc(input logic [2:0] tid, input logic [2:0] off, input logic [1:0] sz,
                          input logic sgn, input logic exp_id);
    alloc_valid = 1'b1;
    alloc_tid   = tid;
    alloc_off   = off;
    alloc_size  = sz;
    alloc_sgn   = sgn;
    probe();
    check("alloc_ready", 64'(alloc_ready), 64'd1);
    check("alloc_id", 64'(alloc_id), 64'(exp_id));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_rsp(input logic id, input logic [63:0] d, input bit expect_wb,
                        input logic [2:0] tid, input logic [63:0] exp);
    rsp_valid = 1'b1;
    rsp_id    = id;
    rsp_data  = d;
    if (expect_wb) sb.push_back('{tid: tid, data: exp, due: cyc + LAT});
    probe();
    tick();
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd5, 3'd4, 2'd2, 1'b1, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
    vecs[1] = '{3'd1, 3'd7, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB};
    vecs[2] = '{3'd2, 3'd7, 2'd0, 1'b1, 64'hAB00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFAB};
    vecs[3] = '{3'd3, 3'd2, 2'd1, 1'b1, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765};
    vecs[4] = '{3'd4, 3'd2, 2'd1, 1'b0, 64'h0000_0000_8765_0000, 64'h0000_0000_0000_8765};
    vecs[5] = '{3'd6, 3'd0, 2'd3, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vecs[6] = '{3'd7, 3'd0, 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_9ABC_DEF0};
    vecs[7] = '{3'd0, 3'd4, 2'd2, 1'b0, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001};
    vecs[8] = '{3'd5, 3'd1, 2'd0, 1'b1, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F};

    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_tid = '0; alloc_off = '0;
    alloc_size = '0; alloc_sgn = 1'b0; rsp_valid = 1'b0; rsp_id = 1'b0; rsp_data = '0;
    tick();
    tick();
    probe();
    check("ready_in_reset", 64'(alloc_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    probe();
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(perr), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_id", 64'(alloc_id), 64'd0);
    tick();

    for (int i = 0; i < 9; i++) begin
      do_alloc(vecs[i].tid, vecs[i].off, vecs[i].size, vecs[i].sgn, 1'b0);
      probe();
      check("vec_count_busy", 64'(count), 64'd1);
      tick();
      do_rsp(1'b0, vecs[i].rdata, 1'b1, vecs[i].tid, vecs[i].exp);
      probe();
      check("vec_count_free", 64'(count), 64'd0);
      tick();
    end

    // Full, then response to id 1 with an allocation attempt in the same cycle.
    do_alloc(3'd1, 3'd0, 2'd3, 1'b0, 1'b0);
    do_alloc(3'd2, 3'd0, 2'd3, 1'b0, 1'b1);
    probe();
    check("full_count", 64'(count), 64'd2);
    check("full_ready", 64'(alloc_ready), 64'd0);
    tick();
    rsp_valid = 1'b1; rsp_id = 1'b1; rsp_data = 64'h0102_0304_0506_0708;
    alloc_valid = 1'b1; alloc_tid = 3'd4;
    sb.push_back('{tid: 3'd2, data: 64'h0102_0304_0506_0708, due: cyc + LAT});
    probe();
    check("no_bypass_ready", 64'(alloc_ready), 64'd0);
    tick();
    rsp_valid = 1'b0; alloc_valid = 1'b0;
    probe();
    check("freed_ready", 64'(alloc_ready), 64'd1);
    check("freed_alloc_id", 64'(alloc_id), 64'd1);
    check("freed_count", 64'(count), 64'd1);
    tick();
    do_rsp(1'b0, 64'hCAFE_F00D_0000_1111, 1'b1, 3'd1, 64'hCAFE_F00D_0000_1111);

    // Flush with two outstanding: both responses are dropped.
    do_alloc(3'd3, 3'd0, 2'd2, 1'b1, 1'b0);
    do_alloc(3'd4, 3'd0, 2'd2, 1'b1, 1'b1);
    flush = 1'b1;
    probe();
    check("flush_ready", 64'(alloc_ready), 64'd0);
    tick();
    flush = 1'b0;
    probe();
    check("flush_count2", 64'(count), 64'd2);
    tick();
    do_rsp(1'b0, 64'h1111_2222_3333_4444, 1'b0, 3'd0, 64'd0);
    probe();
    check("flush_count1", 64'(count), 64'd1);
    tick();
    do_rsp(1'b1, 64'h5555_6666_7777_8888, 1'b0, 3'd0, 64'd0);
    probe();
    check("flush_count0", 64'(count), 64'd0);
    tick();

    // Response in the flush cycle.
    do_alloc(3'd6, 3'd0, 2'd3, 1'b0, 1'b0);
    rsp_valid = 1'b1; rsp_id = 1'b0; rsp_data = 64'h9999_AAAA_BBBB_CCCC; flush = 1'b1;
    probe();
    check("flush_rsp_wb", 64'(wb_valid), 64'd0);
    tick();
    rsp_valid = 1'b0; flush = 1'b0;
    probe();
    check("flush_rsp_count", 64'(count), 64'd0);
    check("flush_rsp_ready", 64'(alloc_ready), 64'd1);
    check("flush_rsp_wb_late", 64'(wb_valid), 64'd0);
    tick();

    // Response to an invalid entry.
    do_alloc(3'd7, 3'd0, 2'd3, 1'b0, 1'b0);
    probe();
    check("err_before", 64'(perr), 64'd0);
    tick();
    do_rsp(1'b1, 64'h0, 1'b0, 3'd0, 64'd0);
    probe();
    check("err_set", 64'(perr), 64'd1);
    check("err_count", 64'(count), 64'd1);
    tick();
    tick();
    tick();
    probe();
    check("err_sticky", 64'(perr), 64'd1);
    tick();
    do_rsp(1'b0, 64'h0000_0000_0000_0042, 1'b1, 3'd7, 64'h0000_0000_0000_0042);
    probe();
    check("err_still", 64'(perr), 64'd1);
    check("err_drain_count", 64'(count), 64'd0);
    tick();

    // Two outstanding, random fields, responses in random order.
    for (int it = 0; it < 12; it++) begin
      logic [2:0]  t[2];
      logic [2:0]  o[2];
      int          s[2];
      bit          g[2];
      logic [63:0] d;
      int          first;
      for (int k = 0; k < 2; k++) begin
        t[k] = 3'($urandom_range(0, 7));
        s[k] = $urandom_range(0, 3);
        o[k] = 3'($urandom_range(0, (8 >> s[k]) - 1) << s[k]);
        g[k] = 1'($urandom_range(0, 1));
        do_alloc(t[k], o[k], 2'(s[k]), g[k], 1'(k));
      end
      first = $urandom_range(0, 1);
      for (int k = 0; k < 2; k++) begin
        int e;
        e = (k == 0) ? first : 1 - first;
        d = {$urandom, $urandom};
        do_rsp(1'(e), d, 1'b1, t[e], model(d, int'(o[e]), s[e], g[e]));
      end
      probe();
      check("rand_count", 64'(count), 64'd0);
      tick();
    end

    rst_n = 1'b0;
    probe();
    check("ready_in_reset2", 64'(alloc_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    probe();
    check("rst2_err", 64'(perr), 64'd0);
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_ready", 64'(alloc_ready), 64'd1);
    tick();
    tick();
    probe();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
